// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB requester arbiter.
package apb_arb_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin search: first set request after i_last, wrapping.
module apb_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        // i == NUM_REQ wraps back to the last owner, so it is considered last
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(i_last) + i) % NUM_REQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one apb_master port among NUM_REQ requesters,
// with a BUSY-cycle timeout that forces completion with err_o.
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ-1:0]             wr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             done_o,
    output logic                           err_o,
    output logic                           m_sel,
    output logic                           m_wr,
    output logic [ADDR_W-1:0]              m_addr,
    output logic [DATA_W-1:0]              m_wdata,
    input  logic                           m_ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_last, w_last_nxt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_sel, w_sel_nxt;
    logic                 r_wr, w_wr_nxt;
    logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
    logic [DATA_W-1:0]    r_wdata, w_wdata_nxt;

    logic [NUM_REQ-1:0]   w_win;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_valid;
    logic                 w_cmpl;
    logic                 w_tout;

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_i),
        .i_last  (r_last),
        .o_gnt   (w_win),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // First two BUSY cycles cover apb_master IDLE->SETUP->ACCESS; ready is ignored there
    assign w_cmpl = (r_cnt >= CNT_W'(2)) && m_ready;
    assign w_tout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_valid) w_state_nxt = ST_BUSY;
            ST_BUSY:    if (w_cmpl || w_tout) w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_sel_nxt   = r_sel;
        w_wr_nxt    = r_wr;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_last_nxt  = r_last;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_gnt_nxt   = w_win;
                    w_sel_nxt   = 1'b1;
                    w_wr_nxt    = wr_i[w_idx];
                    w_addr_nxt  = addr_i[w_idx];
                    w_wdata_nxt = wdata_i[w_idx];
                    w_last_nxt  = w_idx;
                end
            end
            ST_BUSY: begin
                if (w_cmpl || w_tout) begin
                    w_done_nxt = r_gnt;
                    w_err_nxt  = !w_cmpl;
                    w_gnt_nxt  = '0;
                    w_sel_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_sel_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_sel   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_sel   <= w_sel_nxt;
            r_wr    <= w_wr_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign gnt_o   = r_gnt;
    assign done_o  = r_done;
    assign err_o   = r_err;
    assign m_sel   = r_sel;
    assign m_wr    = r_wr;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: randomized transactions against a
// transaction-level round-robin / latency model.
module tb_apb_arbiter;

    localparam int TMO = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        req_i = '0;
    logic [3:0][11:0]  addr_i = '0;
    logic [3:0]        wr_i = '0;
    logic [3:0][31:0]  wdata_i = '0;
    logic [3:0]        gnt_o;
    logic [3:0]        done_o;
    logic              err_o;
    logic              m_sel;
    logic              m_wr;
    logic [11:0]       m_addr;
    logic [31:0]       m_wdata;
    logic              m_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int last_m   = 3;

    apb_arbiter #(
        .NUM_REQ (4),
        .TIMEOUT (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .addr_i  (addr_i),
        .wr_i    (wr_i),
        .wdata_i (wdata_i),
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .m_sel   (m_sel),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    // Winner is the first requester after the previous owner, wrapping around.
    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    // One full ownership: grant, BUSY, done pulse, RELEASE, back in IDLE.
    // Entered and left at a negedge with the arbiter in IDLE.
    task automatic run_txn(input logic [3:0] add_req, input int d,
                           input bit rnd, input bit scr, input bit drop);
        int          w;
        int          k_end;
        bit          exp_err;
        logic [3:0]  oh;
        logic [11:0] a;
        logic        wr;
        logic [31:0] wd;
        req_i = req_i | add_req;
        if (req_i == 4'b0000) req_i = 4'(1 << $urandom_range(0, 3));
        if (rnd) begin
            for (int i = 0; i < 4; i++) begin
                addr_i[i]  = 12'($urandom);
                wdata_i[i] = $urandom;
                wr_i[i]    = 1'($urandom);
            end
        end
        m_ready = 1'b0;
        w  = rr_pick(last_m, req_i);
        oh = 4'(1 << w);
        a  = addr_i[w];
        wr = wr_i[w];
        wd = wdata_i[w];
        if (d > TMO - 1) begin
            k_end = TMO - 1; exp_err = 1'b1;
        end else begin
            k_end = (d < 2) ? 2 : d; exp_err = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (gnt_o !== oh) begin n_fail++; $display("FAIL grant: gnt_o=%b want %b t=%0t", gnt_o, oh, $time); end
        n_checks++; if (m_sel !== 1'b1) begin n_fail++; $display("FAIL grant_sel: m_sel=%b want 1 t=%0t", m_sel, $time); end
        n_checks++; if (m_addr !== a) begin n_fail++; $display("FAIL grant_addr: m_addr=%h want %h t=%0t", m_addr, a, $time); end
        n_checks++; if (m_wr !== wr) begin n_fail++; $display("FAIL grant_wr: m_wr=%b want %b t=%0t", m_wr, wr, $time); end
        n_checks++; if (m_wdata !== wd) begin n_fail++; $display("FAIL grant_wdata: m_wdata=%h want %h t=%0t", m_wdata, wd, $time); end
        n_checks++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL grant_done: done_o=%b want 0000 t=%0t", done_o, $time); end
        for (int k = 0; k <= k_end; k++) begin
            m_ready = (k >= d);
            if (scr) begin
                for (int i = 0; i < 4; i++) begin
                    addr_i[i]  = 12'($urandom);
                    wdata_i[i] = $urandom;
                    wr_i[i]    = 1'($urandom);
                end
                req_i = req_i | (4'($urandom) & ~oh);
            end
            if (drop && k == 1) begin
                req_i[w]  = 1'b0;
                addr_i[w] = 12'h700;
            end
            @(negedge clk);
            if (k < k_end) begin
                n_checks++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL busy_done: done_o=%b want 0000 k=%0d t=%0t", done_o, k, $time); end
                n_checks++; if (gnt_o !== oh) begin n_fail++; $display("FAIL busy_gnt: gnt_o=%b want %b k=%0d", gnt_o, oh, k); end
                n_checks++; if (m_sel !== 1'b1) begin n_fail++; $display("FAIL busy_sel: m_sel=%b want 1 k=%0d", m_sel, k); end
                n_checks++; if (m_addr !== a) begin n_fail++; $display("FAIL busy_addr: m_addr=%h want %h k=%0d", m_addr, a, k); end
                n_checks++; if (m_wdata !== wd || m_wr !== wr) begin n_fail++; $display("FAIL busy_data: m_wdata=%h m_wr=%b want %h %b", m_wdata, m_wr, wd, wr); end
            end
        end
        n_checks++; if (done_o !== oh) begin n_fail++; $display("FAIL done: done_o=%b want %b t=%0t", done_o, oh, $time); end
        n_checks++; if (err_o !== exp_err) begin n_fail++; $display("FAIL done_err: err_o=%b want %b t=%0t", err_o, exp_err, $time); end
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL done_gnt: gnt_o=%b want 0000 t=%0t", gnt_o, $time); end
        n_checks++; if (m_sel !== 1'b0) begin n_fail++; $display("FAIL done_sel: m_sel=%b want 0 t=%0t", m_sel, $time); end
        m_ready  = 1'b0;
        req_i[w] = 1'b0;
        @(negedge clk);
        n_checks++; if (done_o !== 4'b0000 || err_o !== 1'b0) begin n_fail++; $display("FAIL release_pulse: done_o=%b err_o=%b want 0000 0", done_o, err_o); end
        n_checks++; if (gnt_o !== 4'b0000 || m_sel !== 1'b0) begin n_fail++; $display("FAIL release_gap: gnt_o=%b m_sel=%b want 0000 0", gnt_o, m_sel); end
        last_m = w;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_i = 4'b1111;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: gnt_o=%b want 0000", gnt_o); end
        n_checks++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL rst_done: done_o=%b want 0000", done_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: err_o=%b want 0", err_o); end
        n_checks++; if (m_sel !== 1'b0 || m_wr !== 1'b0) begin n_fail++; $display("FAIL rst_sel_wr: m_sel=%b m_wr=%b want 0 0", m_sel, m_wr); end
        n_checks++; if (m_addr !== 12'h000 || m_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_data: m_addr=%h m_wdata=%h want 0 0", m_addr, m_wdata); end
        req_i = 4'b0000;
        m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt_o !== 4'b0000 || m_sel !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: gnt_o=%b m_sel=%b want 0000 0", gnt_o, m_sel); end
        last_m = 3;
    endtask

    task automatic test_single();
        req_i      = 4'b0001;
        addr_i[0]  = 12'h200;
        wr_i[0]    = 1'b1;
        wdata_i[0] = 32'hA5A5_A5A5;
        run_txn(4'b0000, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        for (int n = 0; n < 5; n++) run_txn(4'b1111, $urandom_range(0, 5), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(4'b0010, 1000, 1'b1, 1'b1, 1'b0);
        run_txn(4'b0000, 3, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_hold_and_drop();
        req_i      = 4'b0100;
        addr_i[2]  = 12'h500;
        wr_i[2]    = 1'b0;
        wdata_i[2] = 32'h1234_5678;
        run_txn(4'b0000, 4, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int d;
        for (int n = 0; n < 25; n++) begin
            d = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 10);
            run_txn(4'($urandom), d, 1'b1, 1'($urandom), ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_async_reset();
        req_i      = 4'b1000;
        addr_i[3]  = 12'hABC;
        wdata_i[3] = 32'hDEAD_BEEF;
        wr_i[3]    = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++; if (gnt_o !== 4'b0000 || done_o !== 4'b0000 || err_o !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl: gnt_o=%b done_o=%b err_o=%b want 0", gnt_o, done_o, err_o); end
        n_checks++; if (m_sel !== 1'b0 || m_wr !== 1'b0 || m_addr !== 12'h0 || m_wdata !== 32'h0) begin n_fail++; $display("FAIL arst_bus: sel=%b wr=%b addr=%h wdata=%h want 0", m_sel, m_wr, m_addr, m_wdata); end
        req_i   = 4'b0000;
        m_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_checks++; if (done_o !== 4'b0000 || gnt_o !== 4'b0000) begin n_fail++; $display("FAIL arst_hold: done_o=%b gnt_o=%b want 0000", done_o, gnt_o); end
        end
        m_ready = 1'b0;
        rst     = 1'b1;
        last_m  = 3;
        run_txn(4'b1111, 2, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_hold_and_drop();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
